mem_stage: RTL and testbench

- Memory-access pipeline stage of the 5-stage LoongArch CPU.
- Takes the EX→MEM pipeline bus and receives the data SRAM read response for loads issued by EX in the previous cycle.
- Performs byte/half load alignment and extension, and selects the final writeback value among load, multiply, divide and ALU results.
- Buffers late-arriving SRAM/multiplier data across WB backpressure, and drives the MEM→WB bus plus the MEM forwarding bundle for the decode stage.

---
 rtl/mem_stage_if.sv | 36 +++
 rtl/mem_stage.sv | 96 +++++++++
 tb/tb_mem_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM/WB handshake and data bus seen by the MEM stage
interface mem_stage_if;
   logic         mem_allowin;
   logic         ex_to_mem_valid;
   logic [108:0] ex_to_mem_wire;
   logic         wb_allowin;
   logic         mem_to_wb_valid;
   logic [69:0]  mem_to_wb_wire;
   logic [31:0]  mul_result;
   logic [31:0]  data_sram_rdata;
   logic [37:0]  mem_rf_zip;

   modport master (
      output mem_allowin,
      output mem_to_wb_valid,
      output mem_to_wb_wire,
      output mem_rf_zip,
      input  ex_to_mem_valid,
      input  ex_to_mem_wire,
      input  wb_allowin,
      input  mul_result,
      input  data_sram_rdata
   );

   modport slave (
      input  mem_allowin,
      input  mem_to_wb_valid,
      input  mem_to_wb_wire,
      input  mem_rf_zip,
      output ex_to_mem_valid,
      output ex_to_mem_wire,
      output wb_allowin,
      output mul_result,
      output data_sram_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch MEM stage: load alignment, result select, late-data buffering
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   mem_stage_if.master bus
);
   logic         mem_valid;
   logic         mem_first;
   logic [108:0] ex_to_mem_reg;
   logic [31:0]  rdata_buf;
   logic [31:0]  mul_buf;

   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  pc;
   logic [31:0]  alu_result;
   logic         ld_b, ld_bu, ld_h, ld_hu, ld_w;
   logic         res_from_mul;
   logic         res_from_div;
   logic [31:0]  div_result;

   logic [31:0]  src_word;
   logic [31:0]  mul_value;
   logic [31:0]  shifted;
   logic [7:0]   byte_value;
   logic [15:0]  half_value;
   logic [31:0]  load_value;
   logic [31:0]  final_result;
   logic [1:0]   off;

   assign {rf_we, rf_waddr, pc, alu_result, ld_b, ld_bu, ld_h, ld_hu, ld_w,
           res_from_mul, res_from_div, div_result} = ex_to_mem_reg;
   assign off = alu_result[1:0];

   assign bus.mem_allowin     = ~mem_valid | bus.wb_allowin;
   assign bus.mem_to_wb_valid = mem_valid;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_valid     <= 1'b0;
         mem_first     <= 1'b0;
         ex_to_mem_reg <= '0;
         rdata_buf     <= '0;
         mul_buf       <= '0;
      end else begin
         if (bus.mem_allowin) begin
            mem_valid <= bus.ex_to_mem_valid;
         end
         if (bus.ex_to_mem_valid && bus.mem_allowin) begin
            ex_to_mem_reg <= bus.ex_to_mem_wire;
            mem_first     <= 1'b1;
         end else begin
            mem_first     <= 1'b0;
         end
         // SRAM and multiplier data are only live in the first MEM cycle; keep them for stalls
         if (mem_valid && mem_first) begin
            rdata_buf <= bus.data_sram_rdata;
            mul_buf   <= bus.mul_result;
         end
      end
   end

   always_comb begin
      src_word   = mem_first ? bus.data_sram_rdata : rdata_buf;
      mul_value  = mem_first ? bus.mul_result : mul_buf;
      shifted    = src_word >> {off, 3'b000};
      byte_value = shifted[7:0];
      half_value = off[1] ? src_word[31:16] : src_word[15:0];

      load_value = 32'h0;
      if (ld_w) begin
         load_value = src_word;
      end else if (ld_h) begin
         load_value = {{16{half_value[15]}}, half_value};
      end else if (ld_hu) begin
         load_value = {16'h0, half_value};
      end else if (ld_b) begin
         load_value = {{24{byte_value[7]}}, byte_value};
      end else if (ld_bu) begin
         load_value = {24'h0, byte_value};
      end

      if (ld_w | ld_h | ld_hu | ld_b | ld_bu) begin
         final_result = load_value;
      end else if (res_from_mul) begin
         final_result = mul_value;
      end else if (res_from_div) begin
         final_result = div_result;
      end else begin
         final_result = alu_result;
      end
   end

   assign bus.mem_to_wb_wire = {rf_we, rf_waddr, pc, final_result};
   assign bus.mem_rf_zip     = {rf_we & mem_valid, rf_waddr, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   mem_stage_if bus_if ();

   mem_stage u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic [108:0] mk(input logic we, input logic [4:0] wa,
                                       input logic [31:0] pc, input logic [31:0] alu,
                                       input logic [4:0] ld, input logic mul,
                                       input logic div, input logic [31:0] dr);
      return {we, wa, pc, alu, ld, mul, div, dr};
   endfunction

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive EX/WB side before the edge; caller then sets the first-MEM-cycle data after it
   task automatic cycle(input logic v, input logic [108:0] w, input logic wb);
      @(negedge clk);
      bus_if.ex_to_mem_valid = v;
      bus_if.ex_to_mem_wire  = w;
      bus_if.wb_allowin      = wb;
      @(posedge clk);
      #1;
   endtask

   task automatic mem_data(input logic [31:0] rd, input logic [31:0] mr);
      bus_if.data_sram_rdata = rd;
      bus_if.mul_result      = mr;
      #1;
   endtask

   initial begin
      bus_if.ex_to_mem_valid = 1'b0;
      bus_if.ex_to_mem_wire  = '0;
      bus_if.wb_allowin      = 1'b1;
      bus_if.data_sram_rdata = '0;
      bus_if.mul_result      = '0;

      cycle(1'b1, mk(1, 5'd3, 32'h10, 32'h55, 5'b00000, 0, 0, 0), 1'b1);
      cycle(1'b1, mk(1, 5'd3, 32'h10, 32'h55, 5'b00000, 0, 0, 0), 1'b1);
      chk("rst_allowin", 70'(bus_if.mem_allowin), 70'd1);
      chk("rst_valid", 70'(bus_if.mem_to_wb_valid), 70'd0);
      chk("rst_zip", 70'(bus_if.mem_rf_zip), 70'd0);
      chk("rst_wire", bus_if.mem_to_wb_wire, 70'd0);
      resetn = 1'b1;

      cycle(1'b1, mk(1, 5'd1, 32'h100, 32'h1003, 5'b10000, 0, 0, 0), 1'b1);
      mem_data(32'h80FF_7F01, 32'h0);
      chk("ld_b", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h0FFFF_FF80);
      chk("ld_b_valid", 70'(bus_if.mem_to_wb_valid), 70'd1);

      cycle(1'b1, mk(1, 5'd1, 32'h104, 32'h1003, 5'b01000, 0, 0, 0), 1'b1);
      mem_data(32'h80FF_7F01, 32'h0);
      chk("ld_bu", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h0000_0080);

      cycle(1'b1, mk(1, 5'd1, 32'h108, 32'h1002, 5'b00100, 0, 0, 0), 1'b1);
      mem_data(32'h8001_1234, 32'h0);
      chk("ld_h", 70'(bus_if.mem_to_wb_wire[31:0]), 70'hFFFF_8001);

      cycle(1'b1, mk(1, 5'd1, 32'h10C, 32'h1000, 5'b00010, 0, 0, 0), 1'b1);
      mem_data(32'h8001_1234, 32'h0);
      chk("ld_hu", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h0000_1234);

      cycle(1'b1, mk(1, 5'd1, 32'h110, 32'h1000, 5'b00001, 0, 0, 0), 1'b1);
      mem_data(32'h8001_1234, 32'h0);
      chk("ld_w", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h8001_1234);

      cycle(1'b1, mk(1, 5'd1, 32'h114, 32'h1003, 5'b10001, 0, 0, 0), 1'b1);
      mem_data(32'h8001_1234, 32'h0);
      chk("prio_ldw_over_ldb", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h8001_1234);

      cycle(1'b1, mk(1, 5'd7, 32'h200, 32'h2000, 5'b00001, 0, 0, 0), 1'b1);
      mem_data(32'hDEAD_BEEF, 32'h0);
      chk("stall_first", 70'(bus_if.mem_to_wb_wire[31:0]), 70'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, mk(1, 5'd9, 32'h204, 32'h999, 5'b00000, 0, 0, 0), 1'b0);
         mem_data(32'h0, 32'h0);
         chk($sformatf("stall_result_%0d", i), 70'(bus_if.mem_to_wb_wire[31:0]), 70'hDEAD_BEEF);
         chk($sformatf("stall_pc_%0d", i), 70'(bus_if.mem_to_wb_wire[63:32]), 70'h200);
         chk($sformatf("stall_allowin_%0d", i), 70'(bus_if.mem_allowin), 70'd0);
         chk($sformatf("stall_valid_%0d", i), 70'(bus_if.mem_to_wb_valid), 70'd1);
      end

      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_valid", 70'(bus_if.mem_to_wb_valid), 70'd0);
      chk("midrst_wire", bus_if.mem_to_wb_wire, 70'd0);
      resetn = 1'b1;

      cycle(1'b1, mk(1, 5'd2, 32'h300, 32'h0, 5'b00000, 1, 1, 32'h7), 1'b1);
      mem_data(32'h0, 32'h12);
      chk("mul", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h12);
      cycle(1'b0, '0, 1'b0);
      mem_data(32'h0, 32'h99);
      chk("mul_buffered", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h12);

      cycle(1'b1, mk(1, 5'd2, 32'h304, 32'h0, 5'b00000, 0, 1, 32'h7), 1'b1);
      mem_data(32'h0, 32'h12);
      chk("div", 70'(bus_if.mem_to_wb_wire[31:0]), 70'h7);

      cycle(1'b1, mk(1, 5'd5, 32'h308, 32'h40, 5'b00000, 0, 0, 32'h0), 1'b1);
      mem_data(32'h0, 32'h0);
      chk("alu_zip", 70'(bus_if.mem_rf_zip), 70'({1'b1, 5'd5, 32'h40}));

      cycle(1'b0, mk(1, 5'd6, 32'h999, 32'h77, 5'b00000, 0, 0, 0), 1'b1);
      mem_data(32'h0, 32'h0);
      chk("bubble_valid", 70'(bus_if.mem_to_wb_valid), 70'd0);
      chk("bubble_zip", 70'(bus_if.mem_rf_zip), 70'({1'b0, 5'd5, 32'h40}));
      chk("bubble_hold", bus_if.mem_to_wb_wire, {1'b1, 5'd5, 32'h308, 32'h40});

      cycle(1'b1, mk(1, 5'd10, 32'h400, 32'h111, 5'b00000, 0, 0, 0), 1'b1);
      mem_data(32'h0, 32'h0);
      chk("b2b_a", bus_if.mem_to_wb_wire, {1'b1, 5'd10, 32'h400, 32'h111});
      cycle(1'b1, mk(0, 5'd11, 32'h404, 32'h222, 5'b00000, 0, 0, 0), 1'b1);
      mem_data(32'h0, 32'h0);
      chk("b2b_b", bus_if.mem_to_wb_wire, {1'b0, 5'd11, 32'h404, 32'h222});
      chk("b2b_b_valid", 70'(bus_if.mem_to_wb_valid), 70'd1);
      cycle(1'b0, '0, 1'b1);
      mem_data(32'h0, 32'h0);
      chk("b2b_drained", 70'(bus_if.mem_to_wb_valid), 70'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
